nr_divider_modulo: RTL and testbench
====================================

// Module: nr_divider_modulo
// PURPOSE
//  Pipelined unsigned integer divider/modulo unit using the non-restoring algorithm.
//  Divides a 32-bit dividend by a 16-bit divisor and returns the quotient (mode=0)
//  or the remainder (mode=1) on a 32-bit result bus.
//  Accepts one operation per clock with a fixed latency; sits as an arithmetic
//  execution unit behind an issue stage that needs no back-pressure.
// PARAMETERS
//  BITS_PER_STAGE  4   quotient bits resolved per pipeline stage; legal: 1,2,4,8,16,32
//  (derived) NSTAGE = 32/BITS_PER_STAGE; LATENCY = NSTAGE + 2 clock cycles
// PORTS
//  clk        in   1   rising-edge clock, sole clock domain
//  reset      in   1   synchronous, active-high reset
//  mode       in   1   0 = quotient, 1 = remainder; sampled with the operands
//  valid_in   in   1   operand qualifier; tagged through the pipeline
//  divisor    in   16  unsigned divisor
//  dividend   in   32  unsigned dividend
//  result     out  32  quotient, or remainder zero-extended to 32 bits
//  valid_out  out  1   valid_in delayed by LATENCY cycles
// BEHAVIOUR
//  - Reset: on a rising edge with reset=1, every pipeline register clears to 0:
//    result=0, valid_out=0. Reset during operation discards all in-flight work.
//  - Pipeline: input register (stage 0) -> NSTAGE iteration stages -> output register.
//    Datapath advances every cycle unconditionally; there is no stall or flush input.
//  - Operands sampled on rising edge E appear on result/valid_out right after edge
//    E+LATENCY-1, i.e. LATENCY=10 with the default parameter. One new result per cycle.
//  - valid_in is only a tag: the data path computes and presents a result regardless
//    of valid_in, so result is correct for the sampled operands even when valid_out=0.
//  - mode travels with its operands; back-to-back ops with different modes are legal.
//  - Arithmetic (all unsigned):
//    * partial remainder P: 17-bit two's complement; quotient register Q: 32 bits.
//    * per bit i, MSB first: shift {P,Q} left 1 bit, bringing in dividend bit;
//      if P>=0, P=P-D, else P=P+D (D = divisor zero-extended to 17 bits);
//      new quotient bit = ~P[16].
//    * after 32 bits: if P<0, P=P+D (remainder correction, done in output stage).
//    * result = mode ? {16'b0, P[15:0]} : Q.
//    * Invariant: dividend == Q*divisor + R, 0 <= R < divisor.
//  - Divide by zero (divisor=0): quotient = 32'hFFFF_FFFF, remainder = dividend[15:0]
//    zero-extended (detected at stage 0, flag piped alongside; overrides datapath).
//  - dividend < divisor: quotient 0, remainder = dividend.
//  - divisor=1: quotient = dividend, remainder 0. Max quotient 32'hFFFF_FFFF exact.
//  - Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. reset=1 for 2 cycles -> result=0, valid_out=0; release, all-zero inputs
//     -> valid_out stays 0 for LATENCY cycles.
//  2. valid_in=1, mode=0, dividend=100, divisor=7 -> after 10 cycles
//     result=14, valid_out=1; same with mode=1 -> result=2.
//  3. Back-to-back three cycles: (1000/10,q), (32'hFFFF_FFFF/16'hFFFF,q),
//     (12345/100,r) -> results 100, 65537, 45 on three consecutive cycles.
//  4. valid_in=0, mode=0, dividend=50, divisor=5 -> after 10 cycles result=10,
//     valid_out=0.
//  5. divisor=0, dividend=32'h0001_2345: mode=0 -> 32'hFFFF_FFFF; mode=1
//     -> 32'h0000_2345.
//  6. Assert reset while 5 ops are in flight -> next cycle valid_out=0, result=0;
//     none of the flushed ops emerge. Random check: 10k ops vs / and %, all modes.

Source files
------------

// File: rtl/nr_divider_modulo.sv
// Pipelined unsigned 32/16 non-restoring divider with quotient/remainder select.
// Input register, NSTAGE iteration stages, and a remainder-correcting output register.
module nr_divider_modulo #(
    parameter int BITS_PER_STAGE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        valid_in,
    input  logic [15:0] divisor,
    input  logic [31:0] dividend,
    output logic [31:0] result,
    output logic        valid_out
);

    localparam int NSTAGE = 32 / BITS_PER_STAGE;

    // Per-stage state. Index 0 is the input register.
    // The dividend enters in q and is shifted out into p as quotient bits
    // shift in at the bottom.
    logic [16:0] p_r    [0:NSTAGE];
    logic [31:0] q_r    [0:NSTAGE];
    logic [15:0] d_r    [0:NSTAGE];
    logic        mode_r [0:NSTAGE];
    logic        vld_r  [0:NSTAGE];
    logic        dz_r   [0:NSTAGE];

    logic [16:0] p_n [1:NSTAGE];
    logic [31:0] q_n [1:NSTAGE];

    logic [16:0] rem_fix;
    logic [31:0] res_n;

    // Iteration logic: BITS_PER_STAGE non-restoring steps per stage.
    // p is kept modulo 2^17; the shifted value may wrap, but every add/sub
    // result lies in [-D, D) and is therefore exact.
    always_comb begin
        logic [16:0] p;
        logic [31:0] q;
        logic        neg;
        p = '0;
        q = '0;
        neg = 1'b0;
        for (int s = 1; s <= NSTAGE; s++) begin
            p_n[s] = '0;
            q_n[s] = '0;
        end
        for (int s = 1; s <= NSTAGE; s++) begin
            p = p_r[s-1];
            q = q_r[s-1];
            for (int b = 0; b < BITS_PER_STAGE; b++) begin
                neg = p[16];
                p = {p[15:0], q[31]};
                q = {q[30:0], 1'b0};
                if (neg)
                    p = p + {1'b0, d_r[s-1]};
                else
                    p = p - {1'b0, d_r[s-1]};
                q[0] = ~p[16];
            end
            p_n[s] = p;
            q_n[s] = q;
        end
    end

    // Output selection: final remainder correction and divide-by-zero override.
    // With a zero divisor p ends holding dividend[16:0], so the remainder
    // path already yields dividend[15:0]; only the quotient is forced.
    always_comb begin
        rem_fix = p_r[NSTAGE][16] ? p_r[NSTAGE] + {1'b0, d_r[NSTAGE]}
                                  : p_r[NSTAGE];
        if (mode_r[NSTAGE])
            res_n = {16'b0, rem_fix[15:0]};
        else if (dz_r[NSTAGE])
            res_n = 32'hFFFF_FFFF;
        else
            res_n = q_r[NSTAGE];
    end

    // Pipeline registers: advance every cycle, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= NSTAGE; s++) begin
                p_r[s]    <= '0;
                q_r[s]    <= '0;
                d_r[s]    <= '0;
                mode_r[s] <= 1'b0;
                vld_r[s]  <= 1'b0;
                dz_r[s]   <= 1'b0;
            end
            result    <= '0;
            valid_out <= 1'b0;
        end else begin
            p_r[0]    <= '0;
            q_r[0]    <= dividend;
            d_r[0]    <= divisor;
            mode_r[0] <= mode;
            vld_r[0]  <= valid_in;
            dz_r[0]   <= (divisor == 16'd0);
            for (int s = 1; s <= NSTAGE; s++) begin
                p_r[s]    <= p_n[s];
                q_r[s]    <= q_n[s];
                d_r[s]    <= d_r[s-1];
                mode_r[s] <= mode_r[s-1];
                vld_r[s]  <= vld_r[s-1];
                dz_r[s]   <= dz_r[s-1];
            end
            result    <= res_n;
            valid_out <= vld_r[NSTAGE];
        end
    end

endmodule

// File: tb/tb_nr_divider_modulo.sv
// Directed and randomised checks for nr_divider_modulo.
// Latency is 10 cycles with the default BITS_PER_STAGE of 4.
module tb_nr_divider_modulo;

    localparam int LAT = 10;

    logic        clk;
    logic        reset;
    logic        mode;
    logic        valid_in;
    logic [15:0] divisor;
    logic [31:0] dividend;
    logic [31:0] result;
    logic        valid_out;

    int total;
    int fails;

    nr_divider_modulo dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .valid_in  (valid_in),
        .divisor   (divisor),
        .dividend  (dividend),
        .result    (result),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic m,
                         input logic [31:0] a, input logic [15:0] b);
        valid_in = v;
        mode     = m;
        dividend = a;
        divisor  = b;
    endtask

    function automatic logic [31:0] model(input logic m,
                                          input logic [31:0] a,
                                          input logic [15:0] b);
        if (b == 16'd0)
            return m ? {16'b0, a[15:0]} : 32'hFFFF_FFFF;
        return m ? a % {16'b0, b} : a / {16'b0, b};
    endfunction

    typedef struct {
        logic [31:0] res;
        logic        vld;
    } exp_t;

    exp_t q[$];
    exp_t e;

    initial begin
        logic        rm;
        logic        rv;
        logic [31:0] ra;
        logic [15:0] rb;
        total = 0;
        fails = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 16'd0);

        // 1. reset and idle
        step();
        step();
        check("reset_result", result, 32'd0);
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            step();
            check("idle_valid", {31'b0, valid_out}, 32'd0);
        end

        // 2. 100/7 quotient then remainder
        drive(1'b1, 1'b0, 32'd100, 16'd7);
        step();
        drive(1'b0, 1'b0, 32'd0, 16'd1);
        repeat (LAT - 1) step();
        check("q100_7", result, 32'd14);
        check("q100_7_vld", {31'b0, valid_out}, 32'd1);
        drive(1'b1, 1'b1, 32'd100, 16'd7);
        step();
        drive(1'b0, 1'b0, 32'd0, 16'd1);
        repeat (LAT - 1) step();
        check("r100_7", result, 32'd2);
        check("r100_7_vld", {31'b0, valid_out}, 32'd1);

        // 3. back-to-back mixed modes
        drive(1'b1, 1'b0, 32'd1000, 16'd10);
        step();
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 16'hFFFF);
        step();
        drive(1'b1, 1'b1, 32'd12345, 16'd100);
        step();
        drive(1'b0, 1'b0, 32'd0, 16'd1);
        repeat (LAT - 3) step();
        check("b2b_0", result, 32'd100);
        step();
        check("b2b_1", result, 32'd65537);
        step();
        check("b2b_2", result, 32'd45);
        check("b2b_2_vld", {31'b0, valid_out}, 32'd1);

        // 4. untagged op still computes
        drive(1'b0, 1'b0, 32'd50, 16'd5);
        step();
        drive(1'b0, 1'b0, 32'd0, 16'd1);
        repeat (LAT - 1) step();
        check("untag_res", result, 32'd10);
        check("untag_vld", {31'b0, valid_out}, 32'd0);

        // 5. divide by zero, boundaries
        drive(1'b1, 1'b0, 32'h0001_2345, 16'd0);
        step();
        drive(1'b1, 1'b1, 32'h0001_2345, 16'd0);
        step();
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 16'd1);
        step();
        drive(1'b1, 1'b1, 32'd9, 16'd40);
        step();
        drive(1'b1, 1'b0, 32'd9, 16'd40);
        step();
        drive(1'b0, 1'b0, 32'd0, 16'd1);
        repeat (LAT - 5) step();
        check("dz_q", result, 32'hFFFF_FFFF);
        step();
        check("dz_r", result, 32'h0000_2345);
        step();
        check("div1_q", result, 32'hFFFF_FFFF);
        step();
        check("small_r", result, 32'd9);
        step();
        check("small_q", result, 32'd0);

        // 6. reset with work in flight
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i[0], 32'd1000 + i, 16'd3);
            step();
        end
        drive(1'b0, 1'b0, 32'd0, 16'd1);
        reset = 1'b1;
        step();
        check("flush_result", result, 32'd0);
        check("flush_valid", {31'b0, valid_out}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            check("flush_quiet", {31'b0, valid_out}, 32'd0);
        end

        // random stream against / and %
        for (int t = 0; t < 10000 + LAT; t++) begin
            if (q.size() == LAT) begin
                e = q.pop_front();
                check("rand_res", result, e.res);
                check("rand_vld", {31'b0, valid_out}, {31'b0, e.vld});
            end
            rv = 1'($urandom);
            rm = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 16'($urandom_range(0, 3));
                1: rb = 16'($urandom_range(1, 255));
                2: ra = 32'($urandom_range(0, 70000));
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 4) == 2)
                rb = 16'($urandom);
            drive(rv, rm, ra, rb);
            e.res = model(rm, ra, rb);
            e.vld = rv;
            q.push_back(e);
            step();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
